axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
- REQ-001 Parameter MEM_WORDS, 4096, number of 32-bit words in backing store (power of two).
- REQ-002 Parameter WAIT_CYCLES, 3, extra latency cycles before first R beat and before B response (used only with macro, see REQ-030).
- REQ-003 clk  in  1  sole clock, all logic on rising edge.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  4/32/8/3/2/2/4/3/1  AXI3 read-address channel; arready  out  1.
- REQ-006 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read-data channel; rready  in  1.
- REQ-007 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  4/32/8/3/2/2/4/3/1  write-address channel; awready  out  1.
- REQ-008 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write-data channel; wready  out  1.
- REQ-009 bid/bresp/bvalid  out  4/2/1  write-response channel; bready  in  1.

Function
- REQ-010 Read and write paths are independent FSMs; each accepts one outstanding transaction.
- REQ-011 Word index = addr[2+log2(MEM_WORDS)-1:2]; upper bits ignored, so the index wraps modulo MEM_WORDS, including mid-burst.
- REQ-012 All bursts are treated as INCR of 4-byte beats; arburst/awburst, arsize/awsize, lock/cache/prot are ignored.
- REQ-013 Read FSM states: R_IDLE (arready=1), R_WAIT, R_BURST (rvalid=1); arready is 0 outside R_IDLE.
- REQ-014 On AR handshake: capture arid, index, and arlen; go to R_WAIT; memory read issued next cycle.
- REQ-015 Without macro, R_WAIT lasts 1 cycle: AR handshake in cycle N gives rvalid in cycle N+2.
- REQ-016 In R_BURST, rdata/rid/rlast are held stable while rvalid=1 and rready=0.
- REQ-017 With rready held high, beats are back-to-back (one per cycle); the next word is prefetched on each handshake.
- REQ-018 rlast=1 on beat arlen (beat count from 0); handshake of the last beat returns to R_IDLE in the next cycle; rresp is always 2'b00.
- REQ-019 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
- REQ-020 On AW handshake, capture awid, index, and awlen, then go to W_DATA.
- REQ-021 Each W handshake writes wdata into the current word under wstrb byte enables, then increments the index.
- REQ-022 The beat with count == awlen ends W_DATA and moves to W_RESP.
- REQ-023 bresp=2'b00 if wlast matched the final beat on every beat; otherwise bresp=2'b10 (SLVERR). Data is still written in the SLVERR case.
- REQ-024 bid = captured awid; wid is ignored; bvalid holds until bready, then return to W_IDLE.
- REQ-025 Read and write to the same word in the same cycle: the write commits and the read returns the old data.
- REQ-026 The AR channel may be accepted while a write is in progress, and vice versa.

Reset
- REQ-027 During reset: arready=awready=1, wready=rvalid=bvalid=rlast=0, rid=bid=0, rdata=0, rresp=bresp=0, both FSMs go to IDLE.
- REQ-028 Reset asserted mid-burst abandons the transaction with no further beats or response; memory contents are preserved.
- REQ-029 Memory is not cleared by reset; simulation contents come from an initial image load.

Configuration
- REQ-030 Macro AXI_SRAM_WAIT_EN defined: R_WAIT lasts 1+WAIT_CYCLES cycles, and W_RESP asserts bvalid after WAIT_CYCLES idle cycles, using a shared-width down-counter per FSM.
- REQ-031 Macro undefined: no counters are built, R_WAIT is 1 cycle, and bvalid asserts in the cycle after the last W handshake.

Structure
- REQ-032 Shared package holds AXI resp constants (OKAY, SLVERR), the burst-type enum, and the read and write FSM state enums.
- REQ-033 Sub-module axi_sram_mem: MEM_WORDS x 32 memory with 1 registered read port (with enable) and 1 write port with 4-bit byte enables.

Verification
- REQ-034 AR addr 0x100, arlen 3, rready=1; mem[0x40..0x43]=A,B,C,D -> rdata A,B,C,D in consecutive cycles starting cycle N+2, rlast on D, rid echoes arid.
- REQ-035 Same read with rready toggled 1,0,0,1 -> each beat held stable until accepted, no beat lost or duplicated.
- REQ-036 AW addr 0x200, awlen 0, wdata 0xAABBCCDD, wstrb 4'b0101, prior word 0 -> word becomes 0x00BB00DD, bresp 00, bid echoes awid.
- REQ-037 AW awlen 1 with wlast=1 on the first beat -> two words written, bresp 2'b10.
- REQ-038 Burst starting at index MEM_WORDS-1, len 1 -> second beat accesses index 0.
- REQ-039 Reset asserted after beat 1 of a 4-beat read -> rvalid=0 the next cycle, arready=1, memory unchanged.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI3 SRAM slave.
// Holds the AXI response codes, the burst-type encoding and the state
// encodings of the independent read and write FSMs.
package axi_sram_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Decoded for completeness only: every burst is handled as INCR.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

endpackage

// File: rtl/axi_sram_mem.sv
// Backing store: MEM_WORDS x 32-bit words.
// Ports:
//   i_clk, i_reset              clock; reset clears only the read register
//   i_rd_en, i_rd_idx, o_rd_data registered read port (1-cycle latency)
//   i_wr_en, i_wr_idx, i_wr_data, i_wr_be  write port with byte enables
// A read and write to the same word in one cycle returns the old word.
module axi_sram_mem #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic [3:0]    i_wr_be
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wr_en && i_wr_be[b]) begin
        r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a single-ported-per-direction SRAM.
// Independent read and write FSMs, one outstanding transaction each.
// All bursts are INCR of 4-byte beats; the word index wraps modulo MEM_WORDS.
// Ports: i_clk, i_reset (sync, active-high); AR/R/AW/W/B channel signals
// with i_/o_ prefixes; o_dbg_rstate / o_dbg_wstate expose the FSM states.
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both 1; the source holds payload stable while
// valid=1 and ready=0.
// Macro AXI_SRAM_WAIT_EN: adds WAIT_CYCLES of latency before the first R
// beat and before bvalid, using one down-counter per FSM.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int MEM_WORDS   = 4096,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic [1:0]  i_arlock,
  input  logic [3:0]  i_arcache,
  input  logic [2:0]  i_arprot,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [3:0]  o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [7:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  input  logic [1:0]  i_awlock,
  input  logic [3:0]  i_awcache,
  input  logic [2:0]  i_awprot,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [3:0]  i_wid,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wlast,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready,
  output r_state_t    o_dbg_rstate,
  output w_state_t    o_dbg_wstate
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  // Read path state
  r_state_t      r_rstate;
  logic          r_arready, r_rvalid, r_rlast;
  logic [3:0]    r_rid;
  logic [AW-1:0] r_ridx;
  logic [7:0]    r_rlen, r_rbeat;
  // Write path state
  w_state_t      r_wstate;
  logic          r_awready, r_wready, r_bvalid;
  logic [3:0]    r_bid;
  logic [1:0]    r_bresp;
  logic [AW-1:0] r_widx;
  logic [7:0]    r_wlen, r_wbeat;
  logic          r_werr;

  logic        w_rd_go, w_bv_now, w_bv_late;
  logic        w_rd_en, w_wr_en, w_wfinal;
  logic [31:0] w_rd_data;

`ifdef AXI_SRAM_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] r_rcnt, r_wcnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rcnt <= '0;
    end else if (r_rstate == R_IDLE && i_arvalid) begin
      r_rcnt <= WAIT_LD;
    end else if (r_rstate == R_WAIT && r_rcnt != '0) begin
      r_rcnt <= r_rcnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wcnt <= '0;
    end else if (r_wstate == W_DATA && i_wvalid && w_wfinal) begin
      r_wcnt <= WAIT_LD;
    end else if (r_wstate == W_RESP && !r_bvalid && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - CNT_W'(1);
    end
  end

  assign w_rd_go   = (r_rcnt == '0);
  assign w_bv_now  = (WAIT_CYCLES == 0);
  assign w_bv_late = (r_wcnt == CNT_W'(1));
`else
  assign w_rd_go   = 1'b1;
  assign w_bv_now  = 1'b1;
  assign w_bv_late = 1'b0;
  logic w_unused_wait;
  assign w_unused_wait = (WAIT_CYCLES != 0);
`endif

  // Fetch the first word on leaving R_WAIT, then prefetch on each non-final beat.
  assign w_rd_en = (r_rstate == R_WAIT && w_rd_go) ||
                   (r_rstate == R_BURST && i_rready && !r_rlast);
  assign w_wr_en  = (r_wstate == W_DATA) && i_wvalid;
  assign w_wfinal = (r_wbeat == r_wlen);

  axi_sram_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (r_ridx),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_widx),
    .i_wr_data (i_wdata),
    .i_wr_be   (i_wstrb)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (i_arvalid) begin
          r_rid     <= i_arid;
          r_ridx    <= i_araddr[AW+1:2];
          r_rlen    <= i_arlen;
          r_rbeat   <= '0;
          r_arready <= 1'b0;
          r_rstate  <= R_WAIT;
        end
        R_WAIT: if (w_rd_go) begin
          r_ridx   <= r_ridx + IDX_ONE;
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rlen == 8'd0);
          r_rstate <= R_BURST;
        end
        R_BURST: if (i_rready) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_ridx  <= r_ridx + IDX_ONE;
            r_rbeat <= r_rbeat + 8'd1;
            r_rlast <= (r_rbeat + 8'd1 == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (i_awvalid) begin
          r_bid     <= i_awid;
          r_widx    <= i_awaddr[AW+1:2];
          r_wlen    <= i_awlen;
          r_wbeat   <= '0;
          r_werr    <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (i_wvalid) begin
          r_widx  <= r_widx + IDX_ONE;
          r_wbeat <= r_wbeat + 8'd1;
          // Any beat whose wlast disagrees with its position poisons the response.
          r_werr  <= r_werr | (i_wlast ^ w_wfinal);
          if (w_wfinal) begin
            r_wready <= 1'b0;
            r_bresp  <= (r_werr | (i_wlast ^ w_wfinal)) ? RESP_SLVERR : RESP_OKAY;
            r_bvalid <= w_bv_now;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (!r_bvalid) begin
            if (w_bv_late) r_bvalid <= 1'b1;
          end else if (i_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  logic w_unused_ok;
  assign w_unused_ok = ^{i_arsize, i_arburst, i_arlock, i_arcache, i_arprot,
                         i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_wid,
                         i_araddr[31:AW+2], i_araddr[1:0],
                         i_awaddr[31:AW+2], i_awaddr[1:0]};

  assign o_arready    = r_arready;
  assign o_rid        = r_rid;
  assign o_rdata      = w_rd_data;
  assign o_rresp      = RESP_OKAY;
  assign o_rlast      = r_rlast;
  assign o_rvalid     = r_rvalid;
  assign o_awready    = r_awready;
  assign o_wready     = r_wready;
  assign o_bid        = r_bid;
  assign o_bresp      = r_bresp;
  assign o_bvalid     = r_bvalid;
  assign o_dbg_rstate = r_rstate;
  assign o_dbg_wstate = r_wstate;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic [3:0]  i_arid, i_awid, i_wid;
  logic [31:0] i_araddr, i_awaddr, i_wdata;
  logic [7:0]  i_arlen, i_awlen;
  logic [2:0]  i_arsize, i_arprot, i_awsize, i_awprot;
  logic [1:0]  i_arburst, i_arlock, i_awburst, i_awlock;
  logic [3:0]  i_arcache, i_awcache, i_wstrb;
  logic        i_arvalid, i_rready, i_awvalid, i_wlast, i_wvalid, i_bready;
  logic        o_arready, o_rlast, o_rvalid, o_awready, o_wready, o_bvalid;
  logic [3:0]  o_rid, o_bid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp, o_bresp;
  r_state_t    o_dbg_rstate;
  w_state_t    o_dbg_wstate;

  int checks = 0;
  int failures = 0;

  logic [31:0] wd [4];
  logic        wl [4];
  logic [31:0] rd_got [4];
  logic        rd_last [4];
  logic [31:0] exp_d [4];

  axi_sram_slave dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arlock(i_arlock), .i_arcache(i_arcache), .i_arprot(i_arprot),
    .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awlock(i_awlock), .i_awcache(i_awcache), .i_awprot(i_awprot),
    .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wid(i_wid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .o_dbg_rstate(o_dbg_rstate), .o_dbg_wstate(o_dbg_wstate)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: full write burst using wd[]/wl[]; returns observed B response.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] bid_o);
    int t;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awvalid = 1'b1;
    t = 0;
    while (!o_awready && t < 20) begin tick(); t++; end
    checks++;
    if (t >= 20) begin failures++; $display("FAIL aw_timeout: awready=%b required 1", o_awready); end
    tick();
    i_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      i_wvalid = 1'b1; i_wdata = wd[b]; i_wstrb = strb; i_wlast = wl[b]; i_wid = id;
      t = 0;
      while (!o_wready && t < 20) begin tick(); t++; end
      checks++;
      if (t >= 20) begin failures++; $display("FAIL w_timeout: wready=%b required 1", o_wready); end
      tick();
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    t = 0;
    while (!o_bvalid && t < 20) begin tick(); t++; end
    checks++;
    if (t >= 20) begin failures++; $display("FAIL b_timeout: bvalid=%b required 1", o_bvalid); end
    resp = o_bresp; bid_o = o_bid;
    i_bready = 1'b1;
    tick();
    i_bready = 1'b0;
  endtask

  // Driver: read burst with rready held high; fills rd_got[]/rd_last[].
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int t, b;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arvalid = 1'b1; i_rready = 1'b1;
    tick();
    i_arvalid = 1'b0;
    b = 0; t = 0;
    while (b <= int'(len) && t < 40) begin
      if (o_rvalid) begin rd_got[b] = o_rdata; rd_last[b] = o_rlast; b++; end
      tick(); t++;
    end
    checks++;
    if (t >= 40) begin failures++; $display("FAIL r_timeout: beats=%0d required %0d", b, int'(len) + 1); end
    i_rready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_arready !== 1'b1) begin failures++; $display("FAIL rst_arready: got %b exp 1", o_arready); end
    checks++; if (o_awready !== 1'b1) begin failures++; $display("FAIL rst_awready: got %b exp 1", o_awready); end
    checks++; if (o_wready !== 1'b0) begin failures++; $display("FAIL rst_wready: got %b exp 0", o_wready); end
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b exp 0", o_rvalid); end
    checks++; if (o_bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid: got %b exp 0", o_bvalid); end
    checks++; if (o_rlast !== 1'b0) begin failures++; $display("FAIL rst_rlast: got %b exp 0", o_rlast); end
    checks++; if (o_rid !== 4'h0) begin failures++; $display("FAIL rst_rid: got %h exp 0", o_rid); end
    checks++; if (o_bid !== 4'h0) begin failures++; $display("FAIL rst_bid: got %h exp 0", o_bid); end
    checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h exp 0", o_rdata); end
    checks++; if (o_rresp !== 2'b00) begin failures++; $display("FAIL rst_rresp: got %b exp 00", o_rresp); end
    checks++; if (o_bresp !== 2'b00) begin failures++; $display("FAIL rst_bresp: got %b exp 00", o_bresp); end
    checks++; if (o_dbg_rstate !== R_IDLE || o_dbg_wstate !== W_IDLE) begin
      failures++; $display("FAIL rst_states: got r=%0d w=%0d exp 0 0", o_dbg_rstate, o_dbg_wstate); end
  endtask

  task automatic test_read_burst();
    logic [1:0] resp; logic [3:0] bidv;
    exp_d[0] = 32'h1111_AAAA; exp_d[1] = 32'h2222_BBBB;
    exp_d[2] = 32'h3333_CCCC; exp_d[3] = 32'h4444_DDDD;
    for (int i = 0; i < 4; i++) begin wd[i] = exp_d[i]; wl[i] = (i == 3); end
    axi_write(4'h1, 32'h100, 8'd3, 4'hF, resp, bidv);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL preload_bresp: got %b exp 00", resp); end
    i_arid = 4'h7; i_araddr = 32'h100; i_arlen = 8'd3; i_arvalid = 1'b1; i_rready = 1'b1;
    checks++; if (o_arready !== 1'b1) begin failures++; $display("FAIL rd_arready: got %b exp 1", o_arready); end
    tick();
    i_arvalid = 1'b0;
    checks++; if (o_rvalid !== 1'b0 || o_arready !== 1'b0) begin
      failures++; $display("FAIL rd_wait: rvalid=%b arready=%b exp 0 0", o_rvalid, o_arready); end
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (o_rvalid !== 1'b1 || o_rdata !== exp_d[b] || o_rlast !== (b == 3) ||
          o_rid !== 4'h7 || o_rresp !== 2'b00) begin
        failures++;
        $display("FAIL rd_beat%0d: v=%b d=%h last=%b id=%h resp=%b exp 1 %h %b 7 00",
                 b, o_rvalid, o_rdata, o_rlast, o_rid, o_rresp, exp_d[b], (b == 3));
      end
      tick();
    end
    checks++; if (o_rvalid !== 1'b0 || o_arready !== 1'b1) begin
      failures++; $display("FAIL rd_done: rvalid=%b arready=%b exp 0 1", o_rvalid, o_arready); end
    i_rready = 1'b0;
  endtask

  task automatic test_read_backpressure();
    logic [3:0] pat;
    int b, t;
    pat = 4'b1001;
    i_arid = 4'h4; i_araddr = 32'h100; i_arlen = 8'd3; i_arvalid = 1'b1; i_rready = 1'b0;
    tick();
    i_arvalid = 1'b0;
    b = 0; t = 0;
    while (b < 4 && t < 60) begin
      i_rready = pat[3 - (t % 4)];
      if (o_rvalid) begin
        checks++;
        if (o_rdata !== exp_d[b] || o_rlast !== (b == 3) || o_rid !== 4'h4) begin
          failures++;
          $display("FAIL bp_beat%0d: d=%h last=%b id=%h exp %h %b 4", b, o_rdata, o_rlast, o_rid, exp_d[b], (b == 3));
        end
        if (i_rready) b++;
      end
      tick(); t++;
    end
    i_rready = 1'b0;
    checks++; if (b != 4) begin failures++; $display("FAIL bp_count: beats=%0d exp 4", b); end
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL bp_done: rvalid=%b exp 0", o_rvalid); end
  endtask

  task automatic test_write_strb();
    logic [1:0] resp; logic [3:0] bidv;
    wd[0] = 32'h0; wl[0] = 1'b1;
    axi_write(4'h2, 32'h200, 8'd0, 4'hF, resp, bidv);
    wd[0] = 32'hAABB_CCDD; wl[0] = 1'b1;
    axi_write(4'h5, 32'h200, 8'd0, 4'b0101, resp, bidv);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL strb_bresp: got %b exp 00", resp); end
    checks++; if (bidv !== 4'h5) begin failures++; $display("FAIL strb_bid: got %h exp 5", bidv); end
    checks++; if (dut.u_mem.r_mem[12'h080] !== 32'h00BB_00DD) begin
      failures++; $display("FAIL strb_word: got %h exp 00bb00dd", dut.u_mem.r_mem[12'h080]); end
    checks++; if (o_awready !== 1'b1 || o_bvalid !== 1'b0) begin
      failures++; $display("FAIL strb_idle: awready=%b bvalid=%b exp 1 0", o_awready, o_bvalid); end
  endtask

  task automatic test_write_slverr();
    logic [1:0] resp; logic [3:0] bidv;
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wl[0] = 1'b1; wl[1] = 1'b1;
    axi_write(4'hA, 32'h300, 8'd1, 4'hF, resp, bidv);
    checks++; if (resp !== RESP_SLVERR) begin failures++; $display("FAIL slverr_bresp: got %b exp 10", resp); end
    checks++; if (bidv !== 4'hA) begin failures++; $display("FAIL slverr_bid: got %h exp a", bidv); end
    checks++; if (dut.u_mem.r_mem[12'h0C0] !== 32'h1111_1111 || dut.u_mem.r_mem[12'h0C1] !== 32'h2222_2222) begin
      failures++; $display("FAIL slverr_words: got %h %h exp 11111111 22222222",
                           dut.u_mem.r_mem[12'h0C0], dut.u_mem.r_mem[12'h0C1]); end
  endtask

  task automatic test_wrap();
    logic [1:0] resp; logic [3:0] bidv;
    wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002; wl[0] = 1'b0; wl[1] = 1'b1;
    axi_write(4'h3, 32'h0001_3FFC, 8'd1, 4'hF, resp, bidv);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL wrap_bresp: got %b exp 00", resp); end
    checks++; if (dut.u_mem.r_mem[12'hFFF] !== 32'hCAFE_0001 || dut.u_mem.r_mem[12'h000] !== 32'hCAFE_0002) begin
      failures++; $display("FAIL wrap_words: got %h %h exp cafe0001 cafe0002",
                           dut.u_mem.r_mem[12'hFFF], dut.u_mem.r_mem[12'h000]); end
    axi_read(4'h6, 32'h0000_3FFC, 8'd1);
    checks++; if (rd_got[0] !== 32'hCAFE_0001 || rd_got[1] !== 32'hCAFE_0002 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      failures++; $display("FAIL wrap_read: got %h %h last %b%b exp cafe0001 cafe0002 01",
                           rd_got[0], rd_got[1], rd_last[0], rd_last[1]); end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic [3:0] bidv;
    wd[0] = 32'h0BAD_F00D; wl[0] = 1'b1;
    axi_write(4'h1, 32'h240, 8'd0, 4'hF, resp, bidv);
    i_awid = 4'h3; i_awaddr = 32'h240; i_awlen = 8'd0; i_awvalid = 1'b1;
    tick();
    i_awvalid = 1'b0;
    i_arid = 4'h9; i_araddr = 32'h240; i_arlen = 8'd0; i_arvalid = 1'b1;
    checks++; if (o_arready !== 1'b1 || o_wready !== 1'b1) begin
      failures++; $display("FAIL coll_ready: arready=%b wready=%b exp 1 1", o_arready, o_wready); end
    tick();
    i_arvalid = 1'b0;
    i_wvalid = 1'b1; i_wdata = 32'h1234_5678; i_wstrb = 4'hF; i_wlast = 1'b1;
    tick();
    i_wvalid = 1'b0; i_wlast = 1'b0;
    checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'h0BAD_F00D || o_rid !== 4'h9) begin
      failures++; $display("FAIL coll_rdata: v=%b d=%h id=%h exp 1 0badf00d 9", o_rvalid, o_rdata, o_rid); end
    checks++; if (o_bvalid !== 1'b1 || o_bresp !== 2'b00 || o_bid !== 4'h3) begin
      failures++; $display("FAIL coll_b: v=%b resp=%b id=%h exp 1 00 3", o_bvalid, o_bresp, o_bid); end
    i_rready = 1'b1; i_bready = 1'b1;
    tick();
    i_rready = 1'b0; i_bready = 1'b0;
    checks++; if (dut.u_mem.r_mem[12'h090] !== 32'h1234_5678) begin
      failures++; $display("FAIL coll_word: got %h exp 12345678", dut.u_mem.r_mem[12'h090]); end
    checks++; if (o_rvalid !== 1'b0 || o_bvalid !== 1'b0) begin
      failures++; $display("FAIL coll_idle: rvalid=%b bvalid=%b exp 0 0", o_rvalid, o_bvalid); end
  endtask

  task automatic test_reset_midburst();
    i_arid = 4'h2; i_araddr = 32'h100; i_arlen = 8'd3; i_arvalid = 1'b1; i_rready = 1'b1;
    tick();
    i_arvalid = 1'b0;
    tick();
    checks++; if (o_rvalid !== 1'b1 || o_rdata !== exp_d[0]) begin
      failures++; $display("FAIL mid_beat0: v=%b d=%h exp 1 %h", o_rvalid, o_rdata, exp_d[0]); end
    tick();
    checks++; if (o_rvalid !== 1'b1 || o_rdata !== exp_d[1]) begin
      failures++; $display("FAIL mid_beat1: v=%b d=%h exp 1 %h", o_rvalid, o_rdata, exp_d[1]); end
    i_reset = 1'b1; i_rready = 1'b0;
    tick();
    checks++; if (o_rvalid !== 1'b0 || o_arready !== 1'b1 || o_rlast !== 1'b0 || o_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_reset: v=%b arready=%b last=%b d=%h exp 0 1 0 0",
                           o_rvalid, o_arready, o_rlast, o_rdata); end
    i_reset = 1'b0; i_rready = 1'b1;
    tick(); tick();
    checks++; if (o_rvalid !== 1'b0 || o_dbg_rstate !== R_IDLE) begin
      failures++; $display("FAIL mid_after: v=%b state=%0d exp 0 0", o_rvalid, o_dbg_rstate); end
    i_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.u_mem.r_mem[12'h040 + i] !== exp_d[i]) begin
        failures++; $display("FAIL mid_mem%0d: got %h exp %h", i, dut.u_mem.r_mem[12'h040 + i], exp_d[i]);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_arburst = 2'b01;
    i_arlock = '0; i_arcache = '0; i_arprot = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = 3'd2; i_awburst = 2'b01;
    i_awlock = '0; i_awcache = '0; i_awprot = '0; i_awvalid = 1'b0;
    i_wid = '0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    repeat (3) tick();
    test_reset();
    i_reset = 1'b0;
    tick();
    test_read_burst();
    test_read_backpressure();
    test_write_strb();
    test_write_slverr();
    test_wrap();
    test_collision();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
